// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizing for the physical register free list.
package rename_pkg;

    localparam int PREG_W   = 6;
    localparam int NUM_AREG = 32;
    localparam int NUM_PREG = 64;
    localparam int DEPTH    = NUM_PREG - NUM_AREG;

    typedef logic [PREG_W-1:0] preg_t;

    localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/preg_free_list_if.sv
// Allocation (rename) and release (retire) handshake of the physical register free list.
interface preg_free_list_if;
    import rename_pkg::*;

    logic  alloc_req;
    logic  alloc_valid;
    preg_t alloc_preg;
    logic  rel_valid;
    preg_t rel_preg;

    // master: rename/retire side; slave: the free list itself
    modport master (
        output alloc_req, rel_valid, rel_preg,
        input  alloc_valid, alloc_preg
    );

    modport slave (
        input  alloc_req, rel_valid, rel_preg,
        output alloc_valid, alloc_preg
    );

endinterface

// File: rtl/preg_free_list.sv
// Circular FIFO of free physical register tags: rename pops the head, retire pushes at the tail.
// Optional macro FREELIST_CHECK_EN adds an in-list vector that drops duplicate releases and flags dup_err.
module preg_free_list
    import rename_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    preg_free_list_if.slave  fl,
    output preg_t            free_count,
    output logic             overflow_err,
    output logic             dup_err
);

    localparam int PTR_W = $clog2(DEPTH);

    preg_t            mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    preg_t            count;

    logic pop;
    logic rel_live;
    logic full;
    logic dup_hit;
    logic push;

    assign full     = (count == preg_t'(DEPTH));
    assign pop      = fl.alloc_req && (count != '0);
    // The x0 mapping is never recycled, so a release of tag 0 is a no-op.
    assign rel_live = fl.rel_valid && (fl.rel_preg != PREG_ZERO);
    // A same-cycle pop frees a slot first, so a full list still accepts the push.
    assign push     = rel_live && !dup_hit && (!full || pop);

    assign fl.alloc_valid = (count != '0);
    assign fl.alloc_preg  = mem[head];
    assign free_count     = count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the storage is reset on purpose -- its contents are the initial free tags, not don't-care data.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= preg_t'(NUM_AREG + i);
            end
            head         <= '0;
            tail         <= '0;
            count        <= preg_t'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
            if (push) begin
                mem[tail] <= fl.rel_preg;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + preg_t'(1);
                2'b01:   count <= count - preg_t'(1);
                default: count <= count;
            endcase
            if (rel_live && full && !pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [NUM_PREG-1:0] in_list;

    assign dup_hit = rel_live && in_list[fl.rel_preg];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_list <= {{DEPTH{1'b1}}, {NUM_AREG{1'b0}}};
            dup_err <= 1'b0;
        end else begin
            // Pushed tag is never the popped one: a pushed tag's bit was clear, the head's bit is set.
            if (pop) begin
                in_list[mem[head]] <= 1'b0;
            end
            if (push) begin
                in_list[fl.rel_preg] <= 1'b1;
            end
            if (dup_hit) begin
                dup_err <= 1'b1;
            end
        end
    end
`else
    assign dup_hit = 1'b0;
    assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Directed self-checking bench for preg_free_list with hand-computed expectations.
module tb_preg_free_list;
    import rename_pkg::*;

    logic clk;
    logic rstn;
    preg_t free_count;
    logic overflow_err;
    logic dup_err;

    int total;
    int bad;

    preg_free_list_if fl ();

    preg_free_list dut (
        .clk          (clk),
        .rstn         (rstn),
        .fl           (fl),
        .free_count   (free_count),
        .overflow_err (overflow_err),
        .dup_err      (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are changed and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fl.alloc_req = 1'b0;
        fl.rel_valid = 1'b0;
        fl.rel_preg  = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        idle_inputs();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(fl.alloc_valid), 32'd1);
        check({tag, "_preg"},  32'(fl.alloc_preg),  32'd32);
        check({tag, "_count"}, 32'(free_count),     32'd32);
        check({tag, "_ovf"},   32'(overflow_err),   32'd0);
        check({tag, "_dup"},   32'(dup_err),        32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        #2;
        do_reset();
        step();
        check_reset_state("rst");

        // Full list: a lone release is dropped and flags overflow.
        fl.rel_valid = 1'b1;
        fl.rel_preg  = 6'd5;
        step();
        check("full_drop_count", 32'(free_count),   32'd32);
        check("full_drop_ovf",   32'(overflow_err), 32'd1);
        check("full_drop_head",  32'(fl.alloc_preg), 32'd32);

        // Full list with a same-cycle pop: push accepted, no further effect on the sticky flag.
        fl.alloc_req = 1'b1;
        step();
        check("full_pop_count", 32'(free_count),    32'd32);
        check("full_pop_ovf",   32'(overflow_err),  32'd1);
        check("full_pop_head",  32'(fl.alloc_preg), 32'd33);

        // Reset with activity on the inputs: nothing leaks through the reset edge.
        fl.rel_preg = 6'd7;
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        idle_inputs();
        check_reset_state("rst_mid");

        // Drain all 32 tags in order.
        fl.alloc_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(fl.alloc_valid), 32'd1);
            check($sformatf("drain_preg_%0d", i),  32'(fl.alloc_preg),  32'(32 + i));
            step();
        end
        check("empty_valid", 32'(fl.alloc_valid), 32'd0);
        check("empty_count", 32'(free_count),     32'd0);
        step();
        check("empty_req_valid", 32'(fl.alloc_valid), 32'd0);
        check("empty_req_count", 32'(free_count),     32'd0);

        // Empty list, release 40 then 41 with alloc_req held: no bypass, one-cycle visibility.
        fl.rel_valid = 1'b1;
        fl.rel_preg  = 6'd40;
        check("nobypass_valid", 32'(fl.alloc_valid), 32'd0);
        step();
        check("rel40_valid", 32'(fl.alloc_valid), 32'd1);
        check("rel40_preg",  32'(fl.alloc_preg),  32'd40);
        check("rel40_count", 32'(free_count),     32'd1);
        fl.rel_preg = 6'd41;
        step();
        check("rel41_valid", 32'(fl.alloc_valid), 32'd1);
        check("rel41_preg",  32'(fl.alloc_preg),  32'd41);
        check("rel41_count", 32'(free_count),     32'd1);
        fl.rel_valid = 1'b0;
        step();
        check("drain2_valid", 32'(fl.alloc_valid), 32'd0);
        check("drain2_count", 32'(free_count),     32'd0);

        // Refill to 10 with tags 50..59, then release tag 0.
        fl.alloc_req = 1'b0;
        fl.rel_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fl.rel_preg = preg_t'(50 + i);
            step();
        end
        check("fill10_count", 32'(free_count), 32'd10);
        fl.rel_preg = PREG_ZERO;
        step();
        fl.rel_valid = 1'b0;
        check("x0_count", 32'(free_count),    32'd10);
        check("x0_ovf",   32'(overflow_err),  32'd0);
        check("x0_dup",   32'(dup_err),       32'd0);
        check("x0_head",  32'(fl.alloc_preg), 32'd50);

        // List {33..63}: release 40, which is already free.
        do_reset();
        fl.alloc_req = 1'b1;
        step();
        fl.alloc_req = 1'b0;
        check("pop1_count", 32'(free_count),    32'd31);
        check("pop1_head",  32'(fl.alloc_preg), 32'd33);
        fl.rel_valid = 1'b1;
        fl.rel_preg  = 6'd40;
        step();
        fl.rel_valid = 1'b0;
`ifdef FREELIST_CHECK_EN
        check("dup_count", 32'(free_count), 32'd31);
        check("dup_flag",  32'(dup_err),    32'd1);
`else
        check("dup_count", 32'(free_count), 32'd32);
        check("dup_flag",  32'(dup_err),    32'd0);
`endif
        check("dup_ovf", 32'(overflow_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Circular FIFO of free physical register tags.
- The retire/commit stage pushes back each committed instruction's previous destination preg.
- The rename stage pops one tag per renamed destination.
- This block is the release side of the rename allocation protocol; it owns preg recycling, which rename consumes.

Parameters:
- PREG_W, 6, width of a physical register tag.
- NUM_AREG, 32, architectural registers; pregs 0..NUM_AREG-1 are the initial architectural mappings and start out of the list.
- NUM_PREG, 64, total physical registers; list depth DEPTH = NUM_PREG-NUM_AREG = 32.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- alloc_req  in  1  rename consumes the head tag this cycle.
- alloc_valid  out  1  head tag available (count != 0).
- alloc_preg  out  PREG_W  head tag, show-ahead (valid while alloc_valid).
- rel_valid  in  1  retire releases a tag this cycle.
- rel_preg  in  PREG_W  tag being released.
- free_count  out  PREG_W  number of free tags, 0..DEPTH.
- overflow_err  out  1  sticky: release arrived while full.
- dup_err  out  1  sticky: duplicate release (FREELIST_CHECK_EN only, else tied 0).

Behaviour:
- Reset (rstn=0 at edge):
  - mem[i]=NUM_AREG+i for i=0..DEPTH-1; head=0, tail=0, count=DEPTH.
  - overflow_err=0, dup_err=0.
  - Outputs after reset: alloc_valid=1, alloc_preg=32, free_count=32.
  - Reset mid-operation discards all pending state; no partial updates that cycle.
- Pointers:
  - head and tail are log2(DEPTH)-bit, wrapping DEPTH-1 -> 0.
  - count is a separate PREG_W-bit counter.
- Alloc:
  - alloc_valid = (count!=0).
  - alloc_preg = mem[head], combinational from registers.
  - Pop happens when alloc_req && alloc_valid: head+1, count-1 at the edge.
  - alloc_req while empty is ignored; state is unchanged.
- Release:
  - rel_valid with rel_preg==0 is ignored (x0 mapping never recycled).
  - Otherwise, if count<DEPTH: mem[tail]=rel_preg, tail+1, count+1.
  - If count==DEPTH: the release is dropped and overflow_err is set (sticky until reset).
- Simultaneous pop and push:
  - Both occur; count unchanged; head and tail each advance.
  - When full, a simultaneous pop frees a slot first, so the push is accepted and there is no overflow.
  - When empty, there is no bypass: alloc_valid stays 0 that cycle, and the released tag becomes visible the next cycle.
- Latency: a released tag is allocatable 1 cycle after its release edge at the earliest (when the list was empty).
- free_count = count, registered.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- Defined:
  - Maintain a NUM_PREG-bit in_list vector: reset sets bits NUM_AREG..NUM_PREG-1; pop clears the head's bit; accepted push sets rel_preg's bit.
  - A release whose tag bit is already set is dropped (no push) and sets dup_err, sticky.
- Undefined:
  - No vector; duplicates are pushed blindly.
  - dup_err is tied to 0.

Decomposition:
- Shared package rename_pkg holds:
  - PREG_W, NUM_AREG, NUM_PREG, DEPTH constants.
  - preg_t typedef (logic [PREG_W-1:0]).
  - PREG_ZERO constant.
- No sub-module needed.
- The storage array and pointer logic stay in one module; the check vector is inside an ifdef region.

Test Plan:
- Reset, then idle: alloc_valid=1, alloc_preg=32, free_count=32, both error flags 0.
- alloc_req held 32 cycles: tags 32,33,...,63 in order; then alloc_valid=0, free_count=0; a further alloc_req leaves state unchanged.
- Empty list, release 40 then 41 on consecutive cycles, alloc_req held high: alloc_valid rises the cycle after the first release edge; alloc_preg=40 then 41; free_count returns to 0.
- Full list (after reset), rel_valid with rel_preg=5: dropped, overflow_err=1, free_count stays 32. Repeat with alloc_req same cycle: tag 32 popped, 5 written at tail, free_count=32, overflow_err unchanged.
- rel_valid with rel_preg=0 at count=10: ignored, free_count=10, no error.
- FREELIST_CHECK_EN defined, list state {33..63}, release 40: dropped, dup_err=1. Without the macro: pushed, free_count+1, dup_err=0.
